pipe_ctrl_gen: RTL and testbench

//  Parametrised pipeline control unit, successor to the fixed 5-stage stall controller.

---
 rtl/pipe_ctrl_gen_if.sv | 31 +++
 rtl/pipe_ctrl_gen.sv | 105 ++++++++++
 tb/tb_pipe_ctrl_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_gen_if.sv
// Handshake bundle between the pipeline stage modules and the pipeline control unit.
// The stage side uses the master modport. The controller uses the slave modport.
interface pipe_ctrl_gen_if #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 6,
    parameter int PC_W   = 32
);
    logic [STAGES-1:0] stallreq;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_cycles;
    logic              flush_req;
    logic [PC_W-1:0]   flush_pc;
    logic [STAGES:0]   stall;
    logic [STAGES:0]   flush;
    logic              flush_ack;
    logic              new_pc_valid;
    logic [PC_W-1:0]   new_pc;
    logic              mc_busy;
    logic              mc_done;
    logic [31:0]       stall_cnt;

    modport master (
        output stallreq, mc_start, mc_cycles, flush_req, flush_pc,
        input  stall, flush, flush_ack, new_pc_valid, new_pc, mc_busy, mc_done, stall_cnt
    );

    modport slave (
        input  stallreq, mc_start, mc_cycles, flush_req, flush_pc,
        output stall, flush, flush_ack, new_pc_valid, new_pc, mc_busy, mc_done, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Parametrised pipeline control unit. It builds the stall and flush vectors, runs the
// multi-cycle-op busy counter, produces the redirect PC and keeps a saturating stall counter.
module pipe_ctrl_gen #(
    parameter int STAGES      = 5,
    parameter int MC_STAGE    = 3,
    parameter int FLUSH_STAGE = 4,
    parameter int CNT_W       = 6,
    parameter int PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_gen_if.slave  bus
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_newPcValid;
    logic [PC_W-1:0]  r_newPc;
    logic [31:0]      r_stallCnt;

    logic [STAGES:1]  w_req;
    logic [STAGES:0]  w_stallPre;
    logic [STAGES:0]  w_stall;
    logic [STAGES:0]  w_flush;
    logic             w_flushAccept;
    logic             w_mcAccept;
    logic [CNT_W-1:0] w_mcLen;

    always_comb begin
        w_req = bus.stallreq;
        if (bus.mc_start || (r_cnt != '0)) begin
            w_req[MC_STAGE] = 1'b1;
        end
    end

    // Stage i stalls when any request comes from stage i or a younger-indexed-later stage.
    always_comb begin
        w_stallPre = '0;
        for (int i = 0; i <= STAGES; i++) begin
            for (int j = 1; j <= STAGES; j++) begin
                if (j >= i) begin
                    w_stallPre[i] = w_stallPre[i] | w_req[j];
                end
            end
        end
    end

    assign w_flushAccept = bus.flush_req & ~w_stallPre[FLUSH_STAGE+1];
    assign w_mcAccept    = bus.mc_start & (r_cnt == '0);
    assign w_mcLen       = (bus.mc_cycles == '0) ? CNT_W'(1) : bus.mc_cycles;

    // An accepted flush clears stalls up to the flushing stage and bubbles those stages.
    always_comb begin
        w_stall = w_stallPre;
        w_flush = '0;
        for (int i = 0; i <= STAGES; i++) begin
            if (w_flushAccept && (i <= FLUSH_STAGE)) begin
                w_stall[i] = 1'b0;
                if (i >= 1) begin
                    w_flush[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_flushAccept) begin
            r_cnt <= '0;
        end else if (w_mcAccept) begin
            r_cnt <= w_mcLen - CNT_W'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_newPcValid <= 1'b0;
            r_newPc      <= '0;
        end else begin
            r_newPcValid <= w_flushAccept;
            if (w_flushAccept) begin
                r_newPc <= bus.flush_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_stall[0] && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.flush_ack    = w_flushAccept;
    assign bus.new_pc_valid = r_newPcValid;
    assign bus.new_pc       = r_newPc;
    assign bus.mc_busy      = (r_cnt != '0);
    assign bus.mc_done      = ~w_flushAccept &
                              ((w_mcAccept & (bus.mc_cycles <= CNT_W'(1))) | (r_cnt == CNT_W'(1)));
    assign bus.stall_cnt    = r_stallCnt;
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the stall/flush/multi-cycle rules.
module tb_pipe_ctrl_gen;
    localparam int STAGES      = 5;
    localparam int MC_STAGE    = 3;
    localparam int FLUSH_STAGE = 4;
    localparam int CNT_W       = 6;
    localparam int PC_W        = 32;

    typedef struct {
        logic [STAGES:0] stall;
        logic [STAGES:0] flush;
        logic            flushAck;
        logic            newPcValid;
        logic [PC_W-1:0] newPc;
        logic            mcBusy;
        logic            mcDone;
        logic [31:0]     stallCnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_gen_if #(.STAGES(STAGES), .CNT_W(CNT_W), .PC_W(PC_W)) bus ();

    pipe_ctrl_gen #(
        .STAGES(STAGES), .MC_STAGE(MC_STAGE), .FLUSH_STAGE(FLUSH_STAGE),
        .CNT_W(CNT_W), .PC_W(PC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    exp_t            expQ[$];
    logic [PC_W-1:0] pcQ[$];
    exp_t            monE;
    int              checks = 0;
    int              failures = 0;

    // Model state: stalled cycles of the current op still to come, pending redirect, counter.
    int              opRemain;
    logic            mPcValid;
    logic [PC_W-1:0] mPc;
    longint          mCnt;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic [STAGES-1:0] req,
                                 input logic mcStart, input logic [CNT_W-1:0] mcCycles,
                                 input logic flushReq, input logic [PC_W-1:0] flushPc,
                                 input bit preload);
        exp_t e;
        int   k;
        int   total;
        bit   accept;
        bit   startsNew;
        @(posedge clk);
        #1;
        rst           = rstV;
        bus.stallreq  = req;
        bus.mc_start  = mcStart;
        bus.mc_cycles = mcCycles;
        bus.flush_req = flushReq;
        bus.flush_pc  = flushPc;
        if (preload) begin
            force dut.r_stallCnt = 32'hFFFF_FFFE;
            #1;
            release dut.r_stallCnt;
            mCnt = 64'hFFFF_FFFE;
        end
        k = 0;
        for (int j = 1; j <= STAGES; j++) begin
            if (req[j-1]) k = j;
        end
        if (((opRemain > 0) || mcStart) && (MC_STAGE > k)) k = MC_STAGE;
        accept = flushReq && (k <= FLUSH_STAGE);
        e.stall = '0;
        e.flush = '0;
        for (int i = 0; i <= STAGES; i++) begin
            if ((k > 0) && (i <= k) && !(accept && (i <= FLUSH_STAGE))) e.stall[i] = 1'b1;
            if (accept && (i >= 1) && (i <= FLUSH_STAGE)) e.flush[i] = 1'b1;
        end
        startsNew    = mcStart && (opRemain == 0);
        total        = (mcCycles == '0) ? 1 : int'(mcCycles);
        e.flushAck   = accept;
        e.mcDone     = !accept && ((startsNew && (total == 1)) || (opRemain == 1));
        e.mcBusy     = (opRemain > 0);
        e.newPcValid = mPcValid;
        e.newPc      = mPc;
        e.stallCnt   = 32'(mCnt);
        expQ.push_back(e);
        if (rstV) begin
            opRemain = 0;
            mPcValid = 1'b0;
            mPc      = '0;
            mCnt     = 0;
        end else begin
            if (accept) begin
                opRemain = 0;
                mPc      = flushPc;
                pcQ.push_back(flushPc);
            end else if (startsNew) begin
                opRemain = total - 1;
            end else if (opRemain > 0) begin
                opRemain--;
            end
            mPcValid = accept;
            if (e.stall[0] && (mCnt < 64'hFFFF_FFFF)) mCnt++;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: compares every presented cycle and every redirect pulse against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                monE = expQ.pop_front();
                checkOutput("stall",        64'(bus.stall),        64'(monE.stall));
                checkOutput("flush",        64'(bus.flush),        64'(monE.flush));
                checkOutput("flush_ack",    64'(bus.flush_ack),    64'(monE.flushAck));
                checkOutput("new_pc_valid", 64'(bus.new_pc_valid), 64'(monE.newPcValid));
                checkOutput("new_pc",       64'(bus.new_pc),       64'(monE.newPc));
                checkOutput("mc_busy",      64'(bus.mc_busy),      64'(monE.mcBusy));
                checkOutput("mc_done",      64'(bus.mc_done),      64'(monE.mcDone));
                checkOutput("stall_cnt",    64'(bus.stall_cnt),    64'(monE.stallCnt));
            end
            if (bus.new_pc_valid === 1'b1) begin
                if (pcQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL redirect_unexpected actual new_pc=%0h expected no redirect", bus.new_pc);
                end else begin
                    checkOutput("redirect_pc", 64'(bus.new_pc), 64'(pcQ.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [STAGES-1:0] rReq;
        rst           = 1'b1;
        bus.stallreq  = '0;
        bus.mc_start  = 1'b0;
        bus.mc_cycles = '0;
        bus.flush_req = 1'b0;
        bus.flush_pc  = '0;
        opRemain      = 0;
        mPcValid      = 1'b0;
        mPc           = '0;
        mCnt          = 0;
        repeat (2) @(posedge clk);

        $display("[TB] reset with all stall requests");
        applyStimulus(1'b1, '1, 1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, '1, 1'b0, '0, 1'b0, '0, 1'b0);
        idleCycles(1);

        $display("[TB] ID stall request");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b00010, 1'b0, '0, 1'b0, '0, 1'b0);
        idleCycles(1);

        $display("[TB] multi-cycle ops of length 4 and 0");
        applyStimulus(1'b0, '0, 1'b1, 6'd4, 1'b0, '0, 1'b0);
        idleCycles(4);
        applyStimulus(1'b0, '0, 1'b1, 6'd0, 1'b0, '0, 1'b0);
        idleCycles(2);

        $display("[TB] flush during a busy op");
        applyStimulus(1'b0, '0, 1'b1, 6'd6, 1'b0, '0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'hBFC0_0380, 1'b0);
        idleCycles(3);

        $display("[TB] flush deferred by WB stall");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b10000, 1'b0, '0, 1'b1, 32'h8000_0180, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h8000_0180, 1'b0);
        idleCycles(2);

        $display("[TB] stall counter saturation");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b00001, 1'b0, '0, 1'b0, '0, 1'b0);
        idleCycles(2);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            rReq = STAGES'($urandom & $urandom & $urandom);
            applyStimulus(($urandom_range(0, 99) == 0), rReq,
                          ($urandom_range(0, 5) == 0), CNT_W'($urandom_range(0, 7)),
                          ($urandom_range(0, 5) == 0), $urandom, 1'b0);
        end
        idleCycles(2);

        @(negedge clk);
        #1;
        checkOutput("redirect_pending", 64'(pcQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
